// File: rtl/mem_test_master.sv
// Memory self-test initiator: four-phase write/read-compare over 0..MEM_SIZE-1.
// Optional response watchdog enabled by defining MEM_TEST_TIMEOUT_EN.
module mem_test_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_SIZE       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  wr,
    output logic                  rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  response,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    logic [2:0]            state;
    logic [1:0]            phase;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] pattern;
    logic [DATA_WIDTH-1:0] expected;
    logic                  req_active;
    logic                  accept;
    logic                  wd_expire;

    // Even phases write, odd phases read; phases 2/3 use the inverted pattern.
    assign pattern    = s + DATA_WIDTH'(a);
    assign expected   = phase[1] ? ~pattern : pattern;
    assign req_active = (state == REQ) || (state == WAIT);
    assign accept     = start && ((state == IDLE) || (state == DONE));

    assign wr    = req_active && !phase[0];
    assign rd    = req_active && phase[0];
    assign addr  = a;
    assign wdata = wr ? expected : '0;

`ifdef MEM_TEST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Expires on the WAIT cycle whose increment would reach the limit.
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == REQ)
                wd_cnt <= '0;
            else if (state == WAIT && !response)
                wd_cnt <= wd_cnt + 1'b1;

            if (accept)
                timeout_q <= 1'b0;
            else if (state == WAIT && !response && wd_expire)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            phase          <= '0;
            a              <= '0;
            s              <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        s              <= seed;
                        phase          <= '0;
                        a              <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        state          <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    if (response) begin
                        if (phase[0] && (rdata != expected)) begin
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                            if (err_count == 16'd0)
                                first_err_addr <= a;
                        end
                        state <= GAP;
                    end else if (wd_expire) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= DONE;
                    end
                end
                GAP: begin
                    if (a == LAST_ADDR) begin
                        a <= '0;
                        if (phase == 2'd3) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == 16'd0);
                            state <= DONE;
                        end else begin
                            phase <= phase + 2'd1;
                            state <= REQ;
                        end
                    end else begin
                        a     <= a + 1'b1;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_test_master.sv
// Self-checking bench for mem_test_master: behavioural responder, transaction
// log checked against the four-phase pattern model, table plus corner sequences.
module tb_mem_test_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MS = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] seed;
    logic          wr, rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          response;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic          timeout;

    always #5 clk = ~clk;

    mem_test_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_SIZE(MS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .response(response),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .timeout(timeout)
    );

    // Behavioural responder: answers `lat` cycles after request assertion.
    logic [DW-1:0] mem [MS];
    int unsigned   lat = 1;
    logic [MS-1:0] corrupt = '0;
    logic          hang_en = 1'b0;
    logic          spur = 1'b0;
    logic          resp_q;
    int unsigned   age;

    assign response = resp_q | spur;
    assign rdata    = mem[addr] ^ {{(DW-1){1'b0}}, (rd && corrupt[addr])};

    always @(posedge clk) begin
        if (reset) begin
            resp_q <= 1'b0;
            age    <= 0;
        end else if ((wr || rd) && !resp_q) begin
            if (hang_en && wr && addr == AW'(2)) begin
                age <= age;
            end else if (age + 1 >= lat) begin
                resp_q <= 1'b1;
                age    <= 0;
                if (wr) mem[addr] <= wdata;
            end else begin
                age <= age + 1;
            end
        end else begin
            resp_q <= 1'b0;
            age    <= 0;
        end
    end

    // Monitor: log each new request, flag overlap and instability while held.
    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    txn_t                 log_q[$];
    logic                 prev_req = 1'b0;
    logic [AW+DW+1:0]     prev_snap = '0;
    int                   viol = 0;

    always @(negedge clk) begin
        if (wr && rd) viol++;
        if ((wr || rd) && !prev_req) log_q.push_back('{wr, addr, wdata});
        if ((wr || rd) && prev_req && ({wr, rd, addr, wdata} != prev_snap)) viol++;
        prev_req  = wr || rd;
        prev_snap = {wr, rd, addr, wdata};
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the complete write/read sequence a correct master issues.
    task automatic check_log(input string name, input logic [DW-1:0] sd);
        int bad = 0;
        if (log_q.size() != 4 * MS) bad++;
        for (int k = 0; k < log_q.size() && k < 4 * MS; k++) begin
            int            ph = k / MS;
            int            ad = k % MS;
            logic [DW-1:0] p  = sd + DW'(ad);
            if (log_q[k].w !== (ph % 2 == 0)) bad++;
            if (log_q[k].a !== AW'(ad)) bad++;
            if (ph == 0 && log_q[k].d !== p) bad++;
            if (ph == 2 && log_q[k].d !== ~p) bad++;
        end
        check(name, bad, 0);
    endtask

    typedef struct {
        logic [DW-1:0] seed;
        int unsigned   lat;
        logic [MS-1:0] corrupt;
        bit            poke;
        logic          exp_pass;
        logic [15:0]   exp_err;
        logic [AW-1:0] exp_first;
        int unsigned   exp_cyc;
    } vec_t;

    function automatic vec_t model(input logic [DW-1:0] sd, input int unsigned l,
                                   input logic [MS-1:0] c, input bit pk);
        vec_t v;
        v.seed      = sd;
        v.lat       = l;
        v.corrupt   = c;
        v.poke      = pk;
        v.exp_err   = 16'(2 * $countones(c));
        v.exp_pass  = (c == '0);
        v.exp_first = '0;
        for (int i = MS - 1; i >= 0; i--) if (c[i]) v.exp_first = AW'(i);
        v.exp_cyc   = 4 * MS * (l + 2);
        return v;
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        int n = 0;
        seed    = v.seed;
        lat     = v.lat;
        corrupt = v.corrupt;
        log_q.delete();
        viol = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({name, "_busy"}, {busy, done}, 2'b10);
        while (!done && n < 3000) begin
            @(posedge clk);
            #1 n++;
            start = v.poke && (n == 20);
        end
        start = 1'b0;
        check({name, "_cycles"}, n, v.exp_cyc);
        check({name, "_pass"}, pass, v.exp_pass);
        check({name, "_err"}, err_count, v.exp_err);
        check({name, "_first"}, first_err_addr, v.exp_first);
        check({name, "_timeout"}, timeout, 1'b0);
        check({name, "_proto"}, viol, 0);
        check_log({name, "_log"}, v.seed);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'hA5A5_0000, 1, 16'h0000, 1'b0, 1'b1, 16'd0, 4'h0, 192};
        vecs[1] = '{32'hA5A5_0000, 1, 16'h0080, 1'b0, 1'b0, 16'd2, 4'h7, 192};
        vecs[2] = '{32'h1234_5678, 5, 16'h0000, 1'b0, 1'b1, 16'd0, 4'h0, 448};
        vecs[3] = '{32'hFFFF_FFFF, 1, 16'h0000, 1'b1, 1'b1, 16'd0, 4'h0, 192};
        for (int i = 4; i < 8; i++)
            vecs[i] = model($urandom, $urandom_range(1, 3),
                            MS'($urandom & $urandom & $urandom), bit'($urandom_range(0, 1)));

        reset = 1'b1;
        start = 1'b0;
        seed  = '0;
        for (int i = 0; i < MS; i++) mem[i] = $urandom;
        repeat (2) @(posedge clk);
        #1 check("reset_state",
                 {wr, rd, addr, wdata, busy, done, pass, err_count, first_err_addr, timeout}, 0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
            if (i == 0) begin
                check("p0_addr3_wdata", log_q[3].d, 32'hA5A5_0003);
                check("p2_addr3_wdata", log_q[2 * MS + 3].d, 32'h5A5A_FFFC);
            end
            if (i == 3) check("wrap_addr1_wdata", log_q[1].d, 32'h0000_0000);
        end

        // Response strobes while not busy must be ignored; done must hold.
        @(negedge clk) spur = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("spurious_resp", {busy, done, wr, rd}, 4'b0100);
        spur = 1'b0;

        // Reset in the middle of a test, then a clean rerun with a stray start.
        seed = 32'hDEAD_BEEF;
        lat  = 1;
        corrupt = '0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 check("reset_mid",
                 {wr, rd, addr, wdata, busy, done, pass, err_count, first_err_addr, timeout}, 0);
        @(negedge clk) reset = 1'b0;
        run_vec("after_reset", model(32'h0BAD_F00D, 1, '0, 1'b1));

`ifdef MEM_TEST_TIMEOUT_EN
        begin
            int n = 0;
            hang_en = 1'b1;
            lat     = 1;
            corrupt = '0;
            seed    = 32'h0;
            @(negedge clk) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            while (!done && n < 500) begin
                @(posedge clk);
                #1 n++;
            end
            check("timeout_cycles", n, 15);
            check("timeout_flags", {wr, rd, timeout, done, pass}, 5'b00110);
            hang_en = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
